nes_oam_dma: RTL and testbench

- Sprite OAM DMA engine. Sits on the CPU bus directly upstream of the 64 KB system RAM and acts as a read master to it.
- A CPU write to the DMA register (0x4014) supplies a page byte P. The engine halts the CPU, reads RAM 0xPP00..0xPPFF through the RAM's synchronous 1-cycle read port, and streams the 256 bytes to the PPU OAM data port.
- The top level muxes the RAM addr/cs_n/rw_n onto this block's outputs while mem_bus_en=1.

---
 rtl/nes_oam_dma.sv | 121 ++++++++++++
 tb/tb_nes_oam_dma.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/nes_oam_dma.sv
// nes_oam_dma: sprite OAM DMA engine; halts the CPU and copies RAM page P to the PPU OAM port.
// Optional odd-cycle alignment via OAM_DMA_ODD_ALIGN_EN.
module nes_oam_dma #(
    parameter logic [15:0] DMA_REG_ADDR = 16'h4014,
    parameter int          HALT_CYCLES  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reg_wr,
    input  logic [15:0] reg_addr,
    input  logic [7:0]  reg_wdata,
    output logic        cpu_rdy,
    output logic        mem_bus_en,
    output logic [15:0] mem_addr,
    output logic        mem_cs_n,
    output logic        mem_rw_n,
    input  logic [7:0]  mem_rdata,
    output logic        oam_we,
    output logic [7:0]  oam_wdata,
    output logic        busy,
    output logic        done
);
`ifdef OAM_DMA_ODD_ALIGN_EN
    typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE, DONE} state_t;
    logic cycle_par, align, align_n;
`else
    typedef enum logic [2:0] {IDLE, HALT, READ, WRITE, DONE} state_t;
`endif
    state_t      state, state_n;
    logic [7:0]  page, page_n, idx, idx_n;
    logic [1:0]  hcnt, hcnt_n;
    logic        own_n, rdy_n;

    assign mem_rw_n = 1'b1;

    always_comb begin
        state_n = state;
        page_n  = page;
        idx_n   = idx;
        hcnt_n  = hcnt;
`ifdef OAM_DMA_ODD_ALIGN_EN
        align_n = align;
`endif
        case (state)
            IDLE: if (reg_wr && reg_addr == DMA_REG_ADDR) begin
                state_n = HALT;
                page_n  = reg_wdata;
                idx_n   = 8'd0;
                hcnt_n  = 2'd0;
`ifdef OAM_DMA_ODD_ALIGN_EN
                align_n = cycle_par;
`endif
            end
            HALT: begin
                if (hcnt == 2'(HALT_CYCLES - 1))
`ifdef OAM_DMA_ODD_ALIGN_EN
                    state_n = align ? ALIGN : READ;
`else
                    state_n = READ;
`endif
                else
                    hcnt_n = hcnt + 2'd1;
            end
`ifdef OAM_DMA_ODD_ALIGN_EN
            ALIGN: state_n = READ;
`endif
            READ:  state_n = WRITE;
            WRITE: begin
                if (idx == 8'hFF)
                    state_n = DONE;
                else begin
                    idx_n   = idx + 8'd1;
                    state_n = READ;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        rdy_n = state_n == IDLE || state_n == DONE;
        own_n = state_n == READ || state_n == WRITE;
    end

    // outputs are registered from the next-state decode so they line up with state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            page       <= 8'd0;
            idx        <= 8'd0;
            hcnt       <= 2'd0;
            cpu_rdy    <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_bus_en <= 1'b0;
            mem_cs_n   <= 1'b1;
            mem_addr   <= 16'd0;
            oam_we     <= 1'b0;
            oam_wdata  <= 8'd0;
`ifdef OAM_DMA_ODD_ALIGN_EN
            cycle_par  <= 1'b0;
            align      <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            page       <= page_n;
            idx        <= idx_n;
            hcnt       <= hcnt_n;
            cpu_rdy    <= rdy_n;
            busy       <= !rdy_n;
            done       <= state_n == DONE;
            mem_bus_en <= own_n;
            mem_cs_n   <= !own_n;
            mem_addr   <= own_n ? {page_n, idx_n} : 16'd0;
            oam_we     <= state == WRITE;
            oam_wdata  <= state == WRITE ? mem_rdata : 8'd0;
`ifdef OAM_DMA_ODD_ALIGN_EN
            cycle_par  <= !cycle_par;
            align      <= align_n;
`endif
        end
    end
endmodule

// File: tb/tb_nes_oam_dma.sv
// tb_nes_oam_dma: directed bench for nes_oam_dma with a synchronous RAM model and
// an expected-byte/address scoreboard filled at each trigger.
module tb_nes_oam_dma;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reg_wr = 1'b0;
    logic [15:0] reg_addr = 16'd0;
    logic [7:0]  reg_wdata = 8'd0;
    logic        cpu_rdy, mem_bus_en, mem_cs_n, mem_rw_n, oam_we, busy, done;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rdata, oam_wdata;
    logic [7:0]  ram [0:65535];
    logic [7:0]  rdata_q = 8'hEE;
    logic        tb_par = 1'b0;
    logic [7:0]  q_d [$];
    logic [15:0] q_a [$];
    int          n_cmp = 0, n_err = 0, h0, h1;

    nes_oam_dma dut (
        .clk(clk), .rst_n(rst_n), .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .cpu_rdy(cpu_rdy), .mem_bus_en(mem_bus_en), .mem_addr(mem_addr), .mem_cs_n(mem_cs_n),
        .mem_rw_n(mem_rw_n), .mem_rdata(mem_rdata), .oam_we(oam_we), .oam_wdata(oam_wdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    assign mem_rdata = rdata_q;

    always @(posedge clk) begin
        rdata_q <= (!mem_cs_n && mem_rw_n) ? ram[mem_addr] : 8'hEE;
        tb_par  <= rst_n ? ~tb_par : 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_cpu_rdy"}, 32'(cpu_rdy), 32'd1);
        check({tag, "_bus_en"}, 32'(mem_bus_en), 32'd0);
        check({tag, "_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_cs_n"}, 32'(mem_cs_n), 32'd1);
        check({tag, "_rw_n"}, 32'(mem_rw_n), 32'd1);
        check({tag, "_oam_we"}, 32'(oam_we), 32'd0);
        check({tag, "_oam_wdata"}, 32'(oam_wdata), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    task automatic wait_par(input logic v);
        for (int i = 0; i < 4 && tb_par != v; i++) @(negedge clk);
    endtask

    // Runs one transfer of page p; inj>=0 injects a 0x4014 write, rst_at>=0 resets after that many bytes.
    task automatic run_xfer(input logic [7:0] p, input int inj, input int rst_at, output int halt);
        int got, bph, dn, exp_halt;
        logic fin;
        for (int i = 0; i < 256; i++) begin
            q_d.push_back(p == 8'h02 ? 8'(i) ^ 8'hA5 : ram[{p, 8'(i)}]);
            q_a.push_back({p, 8'(i)});
        end
        @(negedge clk);
`ifdef OAM_DMA_ODD_ALIGN_EN
        exp_halt = 513 + int'(tb_par);
`else
        exp_halt = 513;
`endif
        reg_wr = 1'b1; reg_addr = 16'h4014; reg_wdata = p;
        @(negedge clk);
        reg_wr = 1'b0;
        halt = 0; got = 0; bph = 0; dn = 0; fin = 1'b0;
        for (int c = 0; c < 1500 && !fin; c++) begin
            if (!cpu_rdy) halt++;
            if (mem_bus_en) begin
                check("cs_n_low", 32'(mem_cs_n), 32'd0);
                if (bph == 0) begin
                    if (q_a.size() == 0) check("addr_overrun", 32'(q_a.size()), 32'd1);
                    else check("mem_addr", 32'(mem_addr), 32'(q_a.pop_front()));
                end
                bph ^= 1;
            end
            if (oam_we) begin
                if (q_d.size() == 0) check("data_overrun", 32'(q_d.size()), 32'd1);
                else check("oam_wdata", 32'(oam_wdata), 32'(q_d.pop_front()));
                got++;
            end
            if (done) begin dn++; fin = 1'b1; end
            if (rst_at >= 0 && got == rst_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                check("rst_cpu_rdy", 32'(cpu_rdy), 32'd1);
                check("rst_bus_en", 32'(mem_bus_en), 32'd0);
                check("rst_oam_we", 32'(oam_we), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("rst_no_done", 32'(done), 32'd0);
                end
                q_d.delete();
                q_a.delete();
                return;
            end
            if (c == inj) begin reg_wr = 1'b1; reg_addr = 16'h4014; reg_wdata = 8'h05; end
            else reg_wr = 1'b0;
            @(negedge clk);
        end
        reg_wr = 1'b0;
        check("completed", 32'(fin), 32'd1);
        check("pulse_count", 32'(got), 32'd256);
        check("done_count", 32'(dn), 32'd1);
        check("halt_len", 32'(halt), 32'(exp_halt));
        check("queue_left", 32'(q_d.size() + q_a.size()), 32'd0);
        check_idle("post");
        q_d.delete();
        q_a.delete();
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) ram[a] = 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
        for (int i = 0; i < 256; i++) ram[16'h0200 + 16'(i)] = 8'(i) ^ 8'hA5;
        for (int i = 0; i < 256; i++) ram[16'h0500 + 16'(i)] = 8'h77;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check_idle("reset");
        run_xfer(8'h02, -1, -1, h0);
        run_xfer(8'hFF, -1, -1, h0);
        run_xfer(8'h02, 100, -1, h0);
        run_xfer(8'h02, -1, 37, h0);
        run_xfer(8'h02, -1, -1, h0);
        @(negedge clk);
        reg_wr = 1'b1; reg_addr = 16'h4015; reg_wdata = 8'h02;
        @(negedge clk);
        reg_addr = 16'h2014;
        check_idle("wr4015");
        @(negedge clk);
        reg_wr = 1'b0;
        check_idle("wr2014");
        repeat (3) @(negedge clk);
        check("stray_cpu_rdy", 32'(cpu_rdy), 32'd1);
        wait_par(1'b0);
        run_xfer(8'h02, -1, -1, h0);
        wait_par(1'b1);
        run_xfer(8'h02, -1, -1, h1);
`ifdef OAM_DMA_ODD_ALIGN_EN
        check("align_even", 32'(h0), 32'd513);
        check("align_odd", 32'(h1), 32'd514);
`else
        check("halt_par0", 32'(h0), 32'd513);
        check("halt_par1", 32'(h1), 32'd513);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
